// File: rtl/collision_scan_pkg.sv
// Shared types for the collision scanner: object record, FSM states and the
// saturating subtract used by the contact window tests.
package collision_pkg;

  localparam int OBJ_COORD_W = 11;
  localparam int OBJ_EXT_W   = OBJ_COORD_W + 2;

  typedef struct packed {
    logic [OBJ_COORD_W-1:0] left_x;
    logic [OBJ_COORD_W-1:0] top_y;
    logic [OBJ_COORD_W-1:0] right_x;
    logic [OBJ_COORD_W-1:0] bottom_y;
  } obj_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } cs_state_t;

  // Edge-minus-margin terms clamp at zero instead of wrapping.
  function automatic logic [OBJ_EXT_W-1:0] sat_sub(input logic [OBJ_EXT_W-1:0] a,
                                                   input logic [OBJ_EXT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/collision_scan_if.sv
// Request/result bundle between the physics controller and collision_scan.
// Optional macro COLLISION_HIT_IDX_EN adds the floor_idx result field.
interface collision_scan_if #(
  parameter int OBJ_NUM = 8,
  parameter int COORD_W = 11,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);

  logic                              start;
  logic                              ack;
  logic [X_W-1:0]                    x;
  logic [Y_W-1:0]                    y;
  logic [OBJ_NUM-1:0][4*COORD_W-1:0] objects;
  logic                              busy;
  logic                              done;
  logic                              up;
  logic                              down;
  logic                              left;
  logic                              right;
  logic [COORD_W-1:0]                ceil_y;
  logic [COORD_W-1:0]                floor_y;
  logic [COORD_W-1:0]                wall_l;
  logic [COORD_W-1:0]                wall_r;
`ifdef COLLISION_HIT_IDX_EN
  localparam int IDX_W = $clog2(OBJ_NUM);
  logic [IDX_W-1:0]                  floor_idx;
`endif

  modport master (
`ifdef COLLISION_HIT_IDX_EN
    input  floor_idx,
`endif
    output start, ack, x, y, objects,
    input  busy, done, up, down, left, right,
    input  ceil_y, floor_y, wall_l, wall_r
  );

  modport slave (
`ifdef COLLISION_HIT_IDX_EN
    output floor_idx,
`endif
    input  start, ack, x, y, objects,
    output busy, done, up, down, left, right,
    output ceil_y, floor_y, wall_l, wall_r
  );

endinterface

// File: rtl/collision_scan_test.sv
// Combinational contact test of one object against the player box. Contact
// bits are raw; the caller gates them with valid (non-empty slot).
module collision_test
  import collision_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int BOX_W    = 10,
  parameter int BOX_H    = 20,
  parameter int V_MARGIN = 10,
  parameter int H_MARGIN = 2
) (
  input  obj_t           obj,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           up,
  output logic           down,
  output logic           left,
  output logic           right,
  output logic           valid
);

  localparam logic [OBJ_EXT_W-1:0] ONE = OBJ_EXT_W'(1);
  localparam logic [OBJ_EXT_W-1:0] VM  = OBJ_EXT_W'(V_MARGIN);
  localparam logic [OBJ_EXT_W-1:0] HM  = OBJ_EXT_W'(H_MARGIN);

  logic [OBJ_EXT_W-1:0] l, t, r, b;
  logic [OBJ_EXT_W-1:0] xl, xr, yt, yb;
  logic                 wx, wy;

  assign l  = OBJ_EXT_W'(obj.left_x);
  assign t  = OBJ_EXT_W'(obj.top_y);
  assign r  = OBJ_EXT_W'(obj.right_x);
  assign b  = OBJ_EXT_W'(obj.bottom_y);
  assign xl = OBJ_EXT_W'(x);
  assign yt = OBJ_EXT_W'(y);
  assign xr = xl + OBJ_EXT_W'(BOX_W);
  assign yb = yt + OBJ_EXT_W'(BOX_H);

  assign valid = (r >= l) && (b >= t);
  assign wx    = (xl <= r) && (xr >= l);
  assign wy    = (yt <= b) && (yb >= t);

  // Each direction is a narrow window around the facing edge plus overlap on the other axis.
  assign up    = (yt <= b + ONE) && (yt >= sat_sub(b, VM)) && wx;
  assign down  = (yb + ONE >= t) && (yb <= t + VM) && wx;
  assign left  = (xl <= r + ONE) && (xl >= sat_sub(r, HM)) && wy;
  assign right = (xr + ONE >= l) && (xr <= l + HM) && wy;

endmodule

// File: rtl/collision_scan.sv
// Sequential sweep of the object table, one object per clock, keeping the nearest edge per direction.
// Optional macro COLLISION_HIT_IDX_EN adds floor_idx (index that supplied floor_y).
module collision_scan
  import collision_pkg::*;
#(
  parameter int OBJ_NUM  = 8,
  parameter int COORD_W  = OBJ_COORD_W,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int BOX_W    = 10,
  parameter int BOX_H    = 20,
  parameter int V_MARGIN = 10,
  parameter int H_MARGIN = 2
) (
  input logic             clk,
  input logic             reset,
  collision_scan_if.slave bus
);

  localparam int                IDX_W    = $clog2(OBJ_NUM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OBJ_NUM - 1);

  cs_state_t          state_q, state_d;
  logic               load, scan_en;
  logic [IDX_W-1:0]   idx_q;
  logic [X_W-1:0]     px_q;
  logic [Y_W-1:0]     py_q;
  logic               up_q, down_q, left_q, right_q;
  logic [COORD_W-1:0] ceil_q, floor_q, wall_l_q, wall_r_q;
`ifdef COLLISION_HIT_IDX_EN
  logic [IDX_W-1:0]   floor_idx_q;
`endif

  obj_t cur;
  logic c_up, c_down, c_left, c_right, c_valid;
  logic hit_up, hit_down, hit_left, hit_right;

  assign cur = obj_t'(bus.objects[idx_q]);

  collision_test #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .BOX_W    (BOX_W),
    .BOX_H    (BOX_H),
    .V_MARGIN (V_MARGIN),
    .H_MARGIN (H_MARGIN)
  ) u_test (
    .obj   (cur),
    .x     (px_q),
    .y     (py_q),
    .up    (c_up),
    .down  (c_down),
    .left  (c_left),
    .right (c_right),
    .valid (c_valid)
  );

  assign hit_up    = c_valid & c_up;
  assign hit_down  = c_valid & c_down;
  assign hit_left  = c_valid & c_left;
  assign hit_right = c_valid & c_right;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    scan_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          load    = 1'b1;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        // ack wins; a simultaneous start is dropped and must be re-issued from IDLE.
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || load) begin
      idx_q    <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      ceil_q   <= '0;
      floor_q  <= '0;
      wall_l_q <= '0;
      wall_r_q <= '0;
`ifdef COLLISION_HIT_IDX_EN
      floor_idx_q <= '0;
`endif
      if (reset) begin
        px_q <= '0;
        py_q <= '0;
      end else begin
        px_q <= bus.x;
        py_q <= bus.y;
      end
    end else if (scan_en) begin
      idx_q <= idx_q + IDX_W'(1);
      // Strict compares so that ties keep the earlier edge (and index).
      if (hit_up) begin
        up_q <= 1'b1;
        if (!up_q || (cur.bottom_y > ceil_q)) ceil_q <= cur.bottom_y;
      end
      if (hit_down) begin
        down_q <= 1'b1;
        if (!down_q || (cur.top_y < floor_q)) begin
          floor_q <= cur.top_y;
`ifdef COLLISION_HIT_IDX_EN
          floor_idx_q <= idx_q;
`endif
        end
      end
      if (hit_left) begin
        left_q <= 1'b1;
        if (!left_q || (cur.right_x > wall_l_q)) wall_l_q <= cur.right_x;
      end
      if (hit_right) begin
        right_q <= 1'b1;
        if (!right_q || (cur.left_x < wall_r_q)) wall_r_q <= cur.left_x;
      end
    end
  end

  assign bus.busy    = (state_q == SCAN);
  assign bus.done    = (state_q == DONE);
  assign bus.up      = up_q;
  assign bus.down    = down_q;
  assign bus.left    = left_q;
  assign bus.right   = right_q;
  assign bus.ceil_y  = ceil_q;
  assign bus.floor_y = floor_q;
  assign bus.wall_l  = wall_l_q;
  assign bus.wall_r  = wall_r_q;
`ifdef COLLISION_HIT_IDX_EN
  assign bus.floor_idx = floor_idx_q;
`endif

endmodule
